// File: rtl/hdmi_video_timing.sv
// hdmi_video_timing -- raster timing generator for the HDMI output path.
// Runs on the 74.25 MHz pixel clock and is gated by the PLL lock. Produces
// hsync, vsync, data-enable, pixel coordinates and a frame-start pulse,
// all from one output register stage so every output describes the same
// raster position on the same clock.
// Optional feature: define HDMI_TEST_PATTERN_EN to drive 8 vertical colour
// bars on rgb; without it rgb is a constant zero and no pattern logic exists.
`timescale 1ns/1ps

module hdmi_video_timing #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter bit          SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pll_lock,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        sof,
    output logic [23:0] rgb
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Raster counters are 12 bits wide; a larger raster cannot be represented.
    if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_bad_params
        $error("hdmi_video_timing: raster totals exceed the 12-bit counter range");
    end

    // Region boundaries pre-cast to counter width so every compare is 12-bit.
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    logic        lock_meta;
    logic        lock_s;
    state_t      state;
    logic [11:0] h_cnt;
    logic [11:0] v_cnt;

    logic        de_next;
    logic        hs_next;
    logic        vs_next;
    logic        sof_next;

    // Two-flop synchronizer bringing the asynchronous PLL lock into clk.
    // NOTE: non-blocking assignments make both flops sample their old values
    // on the same edge; blocking here would collapse the chain to one flop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // Run/idle control and raster counters; losing lock abandons the frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    h_cnt <= '0;
                    v_cnt <= '0;
                    if (lock_s) state <= RUN;
                end
                RUN: begin
                    if (!lock_s) begin
                        state <= IDLE;
                        h_cnt <= '0;
                        v_cnt <= '0;
                    end else if (h_cnt == H_LAST) begin
                        h_cnt <= '0;
                        v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
                    end else begin
                        h_cnt <= h_cnt + 12'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    h_cnt <= '0;
                    v_cnt <= '0;
                end
            endcase
        end
    end

    // Region decode of the current counter position.
    // NOTE: every combinational output is given a value on every path, so no
    // latch is inferred.
    always_comb begin
        de_next  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_next  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        vs_next  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        sof_next = (h_cnt == 12'd0) && (v_cnt == 12'd0);
    end

    // Output register: decoded raster while running, reset values otherwise.
    // NOTE: only control and output flops carry a reset; there is no storage
    // array here that would need clearing.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
            de    <= 1'b0;
            x     <= '0;
            y     <= '0;
            sof   <= 1'b0;
        end else if (state == RUN) begin
            hsync <= hs_next ? SYNC_POL : ~SYNC_POL;
            vsync <= vs_next ? SYNC_POL : ~SYNC_POL;
            de    <= de_next;
            x     <= de_next ? h_cnt : 12'd0;
            y     <= de_next ? v_cnt : 12'd0;
            sof   <= sof_next;
        end else begin
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
            de    <= 1'b0;
            x     <= '0;
            y     <= '0;
            sof   <= 1'b0;
        end
    end

`ifdef HDMI_TEST_PATTERN_EN
    // Bars are an eighth of the active width each (160 px at 1280). The index
    // comes from threshold compares, since a bit slice of x would give
    // power-of-two bar widths instead.
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    logic [2:0]  bar_idx;
    logic [23:0] bar_rgb;

    // Bar index and colour lookup for the current column.
    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (h_cnt >= 12'(i * BAR_W)) bar_idx = 3'(i);
        end
        case (bar_idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    // Pattern pixel registered alongside de; black outside active video.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rgb <= '0;
        end else if ((state == RUN) && de_next) begin
            rgb <= bar_rgb;
        end else begin
            rgb <= '0;
        end
    end
`else
    assign rgb = 24'h0;
`endif

endmodule

// File: tb/tb_hdmi_video_timing.sv
// tb_hdmi_video_timing -- self-checking bench for hdmi_video_timing.
// A reduced vertical raster keeps two full frames short; the horizontal
// timing is the real 720p line. Every output is compared on every clock with
// a position-based model, and line/frame measurements are checked against
// figures computed from the timing parameters.
`timescale 1ns/1ps

module tb_hdmi_video_timing;

    localparam int H_ACTIVE = 1280;
    localparam int H_FP     = 110;
    localparam int H_SYNC   = 40;
    localparam int H_BP     = 220;
    localparam int V_ACTIVE = 4;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam bit SYNC_POL = 1'b1;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME   = H_TOTAL * V_TOTAL;

    logic        clk      = 1'b0;
    logic        resetn   = 1'b0;
    logic        pll_lock = 1'b0;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic        sof;
    logic [23:0] rgb;

    always #5 clk = ~clk;

    hdmi_video_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .pll_lock (pll_lock),
        .hsync    (hsync),
        .vsync    (vsync),
        .de       (de),
        .x        (x),
        .y        (y),
        .sof      (sof),
        .rgb      (rgb)
    );

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic        sof;
        logic [23:0] rgb;
    } vid_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   k        = 0;    // raster position index expected on the next compare
    int   cyc      = 0;    // clock edges seen by the bench
    bit   meas     = 1'b0;

    int   t0, de_cycles, hs_cycles, vs_cycles, sof_count, sof_period, last_sof;
    int   hs_rise, de_fall, vs_rise;
    int   de_rises[$];
    vid_t prev;
    logic [23:0] rgb_k0, rgb_k159, rgb_k160, rgb_k1279, rgb_blank;

    // ---------------- reference model ----------------
    function automatic vid_t idle_out();
        vid_t o;
        o    = '0;
        o.hs = ~SYNC_POL;
        o.vs = ~SYNC_POL;
        return o;
    endfunction

`ifdef HDMI_TEST_PATTERN_EN
    function automatic logic [23:0] bar_colour(input int h);
        logic [23:0] tbl [8];
        tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        return tbl[h / (H_ACTIVE / 8)];
    endfunction
`endif

    // Outputs expected kk clocks after the frame-start pixel.
    function automatic vid_t model_at(input int kk);
        int   h;
        int   v;
        vid_t o;
        h     = kk % H_TOTAL;
        v     = (kk / H_TOTAL) % V_TOTAL;
        o.de  = (h < H_ACTIVE) && (v < V_ACTIVE);
        o.hs  = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? SYNC_POL : ~SYNC_POL;
        o.vs  = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? SYNC_POL : ~SYNC_POL;
        o.sof = (h == 0) && (v == 0);
        o.x   = o.de ? 12'(h) : 12'd0;
        o.y   = o.de ? 12'(v) : 12'd0;
`ifdef HDMI_TEST_PATTERN_EN
        o.rgb = o.de ? bar_colour(h) : 24'h0;
`else
        o.rgb = 24'h0;
`endif
        return o;
    endfunction

    function automatic vid_t observed();
        vid_t o;
        o.hs  = hsync;
        o.vs  = vsync;
        o.de  = de;
        o.x   = x;
        o.y   = y;
        o.sof = sof;
        o.rgb = rgb;
        return o;
    endfunction

    // ---------------- checking ----------------
    task automatic check_vid(input string tag, input vid_t obs, input vid_t exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed hs=%b vs=%b de=%b x=%0d y=%0d sof=%b rgb=%h expected hs=%b vs=%b de=%b x=%0d y=%0d sof=%b rgb=%h",
                    tag, obs.hs, obs.vs, obs.de, obs.x, obs.y, obs.sof, obs.rgb,
                    exp.hs, exp.vs, exp.de, exp.x, exp.y, exp.sof, exp.rgb);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            check_vid(tag, observed(), idle_out());
        end
    endtask

    task automatic measure(input vid_t o);
        if (k == 0) t0 = cyc;
        if (o.de) de_cycles++;
        if (o.hs === SYNC_POL) hs_cycles++;
        if (o.vs === SYNC_POL) vs_cycles++;
        if (o.sof) begin
            sof_count++;
            if (last_sof >= 0) sof_period = cyc - last_sof;
            last_sof = cyc;
        end
        if (o.de && !prev.de) de_rises.push_back(cyc);
        if (!o.de && prev.de && de_fall < 0) de_fall = cyc;
        if (o.hs === SYNC_POL && prev.hs !== SYNC_POL && hs_rise < 0) hs_rise = cyc;
        if (o.vs === SYNC_POL && prev.vs !== SYNC_POL && vs_rise < 0) vs_rise = cyc;
        case (k)
            0:    rgb_k0    = o.rgb;
            159:  rgb_k159  = o.rgb;
            160:  rgb_k160  = o.rgb;
            1279: rgb_k1279 = o.rgb;
            1300: rgb_blank = o.rgb;
            default: ;
        endcase
        prev = o;
    endtask

    task automatic run_ticks(input int n);
        vid_t o;
        for (int i = 0; i < n; i++) begin
            tick();
            o = observed();
            check_vid($sformatf("raster k=%0d", k), o, model_at(k));
            if (meas) measure(o);
            k++;
        end
    endtask

    // pll_lock held low for d_low sampled edges: the raster keeps running for
    // three edges, sits idle for d_low edges, then restarts at (0,0).
    task automatic lock_drop(input int d_low);
        pll_lock = 1'b0;
        for (int e = 0; e < d_low + 3; e++) begin
            if (e == d_low) pll_lock = 1'b1;
            if (e < 3) run_ticks(1);
            else idle_ticks(1, "lock loss idle");
        end
        k = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset held, then released with the PLL still unlocked.
        tick();
        tick();
        tick();
        check_vid("in reset", observed(), idle_out());
        resetn = 1'b1;
        idle_ticks(40, "unlocked idle");

        // Lock: three idle edges, then (0,0) with sof on the fourth.
        pll_lock = 1'b1;
        idle_ticks(3, "lock latency");
        k          = 0;
        de_cycles  = 0;
        hs_cycles  = 0;
        vs_cycles  = 0;
        sof_count  = 0;
        sof_period = -1;
        last_sof   = -1;
        hs_rise    = -1;
        de_fall    = -1;
        vs_rise    = -1;
        t0         = -1;
        prev       = idle_out();
        meas       = 1'b1;
        run_ticks(2 * FRAME);
        meas       = 1'b0;

        // Line and frame measurements.
        check_int("sof count", sof_count, 2);
        check_int("sof period", sof_period, FRAME);
        check_int("de lines", de_rises.size(), 2 * V_ACTIVE);
        check_int("de clocks", de_cycles, 2 * H_ACTIVE * V_ACTIVE);
        check_int("de width", de_fall - t0, H_ACTIVE);
        check_int("de rise spacing", (de_rises.size() >= 2) ? de_rises[1] - de_rises[0] : -1, H_TOTAL);
        check_int("hsync start", hs_rise - t0, H_ACTIVE + H_FP);
        check_int("de to hsync", hs_rise - de_fall, H_FP);
        check_int("hsync clocks", hs_cycles, 2 * V_TOTAL * H_SYNC);
        check_int("vsync start", vs_rise - t0, (V_ACTIVE + V_FP) * H_TOTAL);
        check_int("vsync clocks", vs_cycles, 2 * V_SYNC * H_TOTAL);
`ifdef HDMI_TEST_PATTERN_EN
        check_int("rgb x=0", int'(rgb_k0), 32'hFFFFFF);
        check_int("rgb x=159", int'(rgb_k159), 32'hFFFFFF);
        check_int("rgb x=160", int'(rgb_k160), 32'hFFFF00);
        check_int("rgb x=1279", int'(rgb_k1279), 32'h000000);
        check_int("rgb blank", int'(rgb_blank), 32'h000000);
`else
        check_int("rgb x=0", int'(rgb_k0), 0);
        check_int("rgb x=160", int'(rgb_k160), 0);
        check_int("rgb blank", int'(rgb_blank), 0);
`endif

        // Lock loss at (600,3), then relock to a fresh frame.
        run_ticks(2 * FRAME + 3 * H_TOTAL + 600 - k + 1);
        check_int("drop point x", int'(x), 600);
        check_int("drop point y", int'(y), 3);
        lock_drop(int'($urandom_range(4, 40)));
        run_ticks(2 * H_TOTAL);

        // Asynchronous reset pulsed mid-line at h=1000.
        run_ticks(((1000 - (k % H_TOTAL)) + H_TOTAL) % H_TOTAL + 1);
        #2 resetn = 1'b0;
        #1;
        check_vid("async reset", observed(), idle_out());
        idle_ticks(4, "held in reset");
        resetn = 1'b1;
        idle_ticks(3, "relock after reset");
        k = 0;
        run_ticks(H_TOTAL + 20);

        // Random run lengths and lock dropouts.
        repeat (4) begin
            run_ticks(int'($urandom_range(50, 1500)));
            lock_drop(int'($urandom_range(1, 12)));
        end
        run_ticks(H_TOTAL);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
